uop_dispatch_arbiter: RTL and testbench
=======================================

# uop_dispatch_arbiter

Shares the single decoder input port between the type-sorted micro-op lanes that leave the front end's sort stage. Lanes are ALU, MEM and TERM. Non-terminating lanes are granted round-robin, gated by a credit count of free downstream reservation-station slots. A TERM micro-op acts as a drain barrier: it issues only after every other lane has emptied, then the front end halts until `wakeup`. A registered one-entry output stage gives the decoder a clean valid/ready boundary.

## Interface
- `LANES`, 3: number of request lanes; lane `LANES-1` is the TERM lane, lanes `0..LANES-2` are ordinary.
- `UOP_W`, 24: micro-op width in bits.
- `CREDITS`, 8: downstream slot count; also the reset value of the credit counter.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `lane_uop` in `LANES*UOP_W`: lane i occupies bits `[i*UOP_W +: UOP_W]`.
- `lane_valid` in `LANES`: per-lane request.
- `lane_ready` out `LANES`: combinational one-hot grant; a transfer is `lane_valid[i] & lane_ready[i]`.
- `wakeup` in 1: leaves HALT.
- `out_uop` out `UOP_W`: registered granted micro-op.
- `out_lane` out `$clog2(LANES)`: source lane of `out_uop`.
- `out_valid` out 1: output register occupied.
- `out_ready` in 1: decoder accepts `out_uop`.
- `credit_return` in 1: one downstream slot freed this cycle.
- `credits` out `$clog2(CREDITS+1)`: current credit count.
- `halted` out 1: state is HALT.

## Operation
- States are RUN, DRAIN and HALT. Reset enters RUN.
- **Slot free:** `slot = !out_valid | out_ready`. No grant is possible unless `slot & (credits != 0)`.
- **RUN:**
  - Round-robin among ordinary lanes with `lane_valid` set.
  - Search starts at `rr_ptr+1` and wraps at `LANES-1`.
  - On a grant, `rr_ptr` takes the granted index.
  - If `lane_valid[TERM]` is set, the TERM lane is never granted in RUN; the next state is DRAIN. Ordinary grants continue in that same cycle.
- **DRAIN:**
  - Ordinary lanes are granted exactly as in RUN.
  - TERM is granted only when all three hold: all ordinary `lane_valid` are 0, `out_valid` is 0 or is being consumed this cycle, and credits are available.
  - A TERM grant moves to HALT, unless `wakeup` is high in the same cycle, in which case the next state is RUN.
- **HALT:**
  - `lane_ready` is 0.
  - The output register keeps draining normally.
  - `wakeup` moves to RUN next cycle.
  - `wakeup` in RUN or DRAIN is ignored.
- **Grant effect:** on the next edge, `out_uop` and `out_lane` load the granted lane, `out_valid` is set, and `credits` decrements by 1.
- **Output register:**
  - Holds its value while `out_valid & !out_ready`.
  - Clears `out_valid` on `out_ready` when there is no new grant.
- **Credits:**
  - `credits_next = credits - grant + credit_return`. A simultaneous grant and return gives a net change of 0.
  - A return at `credits == CREDITS` with no grant is ignored (saturation).
  - Credits never underflow, because a grant requires nonzero credits.
- **Reset values:** `rr_ptr` = `LANES-2`, so lane 0 wins first. `out_valid` 0, `out_uop` 0, `out_lane` 0, `credits` = `CREDITS`, `halted` 0, `lane_ready` 0, state RUN.
- **Reset mid-operation:** any held micro-op is discarded and credits are restored to `CREDITS`. Upstream re-presents its data.

## Timing
- Grant to `out_valid` latency is 1 cycle.
- Sustained throughput is 1 micro-op per cycle while `out_ready` is 1 and credits are nonzero.
- `lane_ready` depends combinationally on `lane_valid`, `out_ready`, `credits` and state. There is no path from `lane_uop`.
- `halted` is registered and asserts the cycle after the TERM grant.
- A TERM micro-op reaches `out_valid` no earlier than 1 cycle after the last ordinary micro-op leaves the output register. It never shares a cycle with an ordinary grant.
- With `credits == 0`, a `credit_return` enables a grant in the following cycle, not the same one.

## Test plan
- **Round-robin:** hold lanes 0 and 1 valid with `out_ready=1` and CREDITS=8 → grants alternate 0,1,0,1 starting at lane 0; `credits` falls 8→4 after four grants.
- **Credit stall:** CREDITS=2, lane 0 valid continuously, no returns → exactly 2 grants, then `lane_ready`=0. Pulse `credit_return` once → exactly one more grant, 1 cycle later.
- **Backpressure:** `out_ready`=0 with lane 1 valid → one grant; `out_uop` held stable and `lane_ready`=0 for 5 cycles. Raise `out_ready` → next grant is issued in the same cycle.
- **Drain barrier:** lanes 0, 1 and TERM valid together, each presenting a single micro-op → output order is lane 0, lane 1, then TERM; `halted`=1 the cycle after the TERM grant; new lane-0 requests stay ungranted until `wakeup`, then are granted 1 cycle after the state returns to RUN.
- **Simultaneous TERM grant and wakeup:** TERM granted in the same cycle `wakeup`=1 → `halted` never asserts; the next state is RUN.
- **Reset mid-flight:** with `out_valid`=1 and `credits`=3, drive `rst_n`=0 for one edge → `out_valid`=0, `credits`=8, state RUN, and the first grant afterwards goes to lane 0.

Source files
------------

// File: rtl/uop_dispatch_arbiter.sv
// Arbitrates the type-sorted micro-op lanes onto the single decoder port.
// Ordinary lanes share round-robin under a credit limit; the TERM lane is a drain barrier.
module uop_dispatch_arbiter #(
    parameter int LANES   = 3,
    parameter int UOP_W   = 24,
    parameter int CREDITS = 8,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int CRED_W = $clog2(CREDITS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES*UOP_W-1:0] lane_uop_i,
    input  logic [LANES-1:0]       lane_valid_i,
    output logic [LANES-1:0]       lane_ready_o,
    input  logic                   wakeup_i,
    output logic [UOP_W-1:0]       out_uop_o,
    output logic [LANE_W-1:0]      out_lane_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    input  logic                   credit_return_i,
    output logic [CRED_W-1:0]      credits_o,
    output logic                   halted_o
);

    localparam int TERM = LANES - 1;
    localparam int NORD = LANES - 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [LANE_W-1:0] rr_q, rr_d;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic [UOP_W-1:0]  out_uop_q;
    logic [LANE_W-1:0] out_lane_q;
    logic              out_valid_q;
    logic              halted_q;

    logic              slot;
    logic              can_grant;
    logic              ord_found;
    logic [LANE_W-1:0] ord_idx;
    logic              grant_any;
    logic [LANE_W-1:0] grant_lane;
    logic [LANES-1:0]  grant_vec;
    logic              ret_eff;
    int                idx;

    // Round-robin search over ordinary lanes, starting one past the last winner.
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        ord_found = 1'b0;
        ord_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NORD; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NORD) begin
                idx = idx - NORD;
            end
            if (!ord_found && lane_valid_i[LANE_W'(idx)]) begin
                ord_found = 1'b1;
                ord_idx   = LANE_W'(idx);
            end
        end
    end

    always_comb begin
        slot       = !out_valid_q || out_ready_i;
        can_grant  = slot && (credits_q != '0);
        state_d    = state_q;
        rr_d       = rr_q;
        grant_any  = 1'b0;
        grant_lane = '0;
        grant_vec  = '0;

        case (state_q)
            S_RUN, S_DRAIN: begin
                if (can_grant && ord_found) begin
                    grant_any  = 1'b1;
                    grant_lane = ord_idx;
                    rr_d       = ord_idx;
                end else if (state_q == S_DRAIN && can_grant && lane_valid_i[TERM]) begin
                    // TERM only goes out once every ordinary lane is empty.
                    grant_any  = 1'b1;
                    grant_lane = LANE_W'(TERM);
                    state_d    = wakeup_i ? S_RUN : S_HALT;
                end
                if (state_q == S_RUN && lane_valid_i[TERM]) begin
                    state_d = S_DRAIN;
                end
            end
            S_HALT: begin
                if (wakeup_i) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        if (grant_any) begin
            grant_vec[grant_lane] = 1'b1;
        end

        // A return into a full counter is dropped unless a grant consumes a slot alongside it.
        ret_eff   = credit_return_i && !((credits_q == CRED_W'(CREDITS)) && !grant_any);
        credits_d = credits_q - CRED_W'(grant_any) + CRED_W'(ret_eff);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            rr_q        <= LANE_W'(LANES - 2);
            credits_q   <= CRED_W'(CREDITS);
            out_uop_q   <= '0;
            out_lane_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            credits_q <= credits_d;
            halted_q  <= (state_d == S_HALT);
            if (grant_any) begin
                out_uop_q   <= lane_uop_i[grant_lane*UOP_W +: UOP_W];
                out_lane_q  <= grant_lane;
                out_valid_q <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign lane_ready_o = grant_vec;
    assign out_uop_o    = out_uop_q;
    assign out_lane_o   = out_lane_q;
    assign out_valid_o  = out_valid_q;
    assign credits_o    = credits_q;
    assign halted_o     = halted_q;

`ifndef SYNTHESIS
    a_onehot_ready : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(lane_ready_o));
    a_halt_quiet : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_HALT) |-> (lane_ready_o == '0));
    a_credit_bound : assert property (@(posedge clk) disable iff (!rst_n)
        credits_q <= CRED_W'(CREDITS));
    a_hold_output : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !out_ready_i) |=> (out_valid_q && $stable(out_uop_q)));
`endif

endmodule

// File: tb/tb_uop_dispatch_arbiter.sv
// Directed bench for uop_dispatch_arbiter: inputs change on the falling edge,
// combinational grants are sampled 1 ns later, registered outputs at the next falling edge.
module tb_uop_dispatch_arbiter;

    localparam int LANES   = 3;
    localparam int UOP_W   = 24;
    localparam int CREDITS = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [LANES*UOP_W-1:0] lane_uop;
    logic [LANES-1:0]       lane_valid;
    logic [LANES-1:0]       lane_ready;
    logic                   wakeup;
    logic [UOP_W-1:0]       out_uop;
    logic [1:0]             out_lane;
    logic                   out_valid;
    logic                   out_ready;
    logic                   credit_return;
    logic [3:0]             credits;
    logic                   halted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uop_dispatch_arbiter #(
        .LANES  (LANES),
        .UOP_W  (UOP_W),
        .CREDITS(CREDITS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lane_uop_i     (lane_uop),
        .lane_valid_i   (lane_valid),
        .lane_ready_o   (lane_ready),
        .wakeup_i       (wakeup),
        .out_uop_o      (out_uop),
        .out_lane_o     (out_lane),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .credit_return_i(credit_return),
        .credits_o      (credits),
        .halted_o       (halted)
    );

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_uops(input logic [UOP_W-1:0] u0, input logic [UOP_W-1:0] u1,
                            input logic [UOP_W-1:0] u2);
        lane_uop = {u2, u1, u0};
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        lane_valid    = '0;
        wakeup        = 1'b0;
        out_ready     = 1'b1;
        credit_return = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        lane_valid    = '0;
        wakeup        = 1'b0;
        out_ready     = 1'b0;
        credit_return = 1'b0;
        set_uops(24'h123456, 24'h654321, 24'habcdef);
        next_cycle();
        next_cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (out_uop !== 24'h0) begin bad++; $display("FAIL reset_out_uop: got %h expected 000000", out_uop); end
        total++; if (out_lane !== 2'd0) begin bad++; $display("FAIL reset_out_lane: got %0d expected 0", out_lane); end
        total++; if (credits !== 4'd8) begin bad++; $display("FAIL reset_credits: got %0d expected 8", credits); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b expected 0", halted); end
        total++; if (lane_ready !== 3'b000) begin bad++; $display("FAIL reset_lane_ready: got %b expected 000", lane_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [2:0]       exp_rdy;
        logic [1:0]       exp_lane;
        logic [UOP_W-1:0] exp_uop;
        do_reset();
        set_uops(24'h100000, 24'h111111, 24'h222222);
        lane_valid = 3'b011;
        out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_lane = 2'(i % 2);
            exp_rdy  = (exp_lane == 2'd0) ? 3'b001 : 3'b010;
            exp_uop  = (exp_lane == 2'd0) ? 24'h100000 : 24'h111111;
            #1;
            total++; if (lane_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, lane_ready, exp_rdy); end
            next_cycle();
            total++; if ({out_valid, out_lane, out_uop} !== {1'b1, exp_lane, exp_uop}) begin
                bad++; $display("FAIL rr_output[%0d]: got v=%b lane=%0d uop=%h expected v=1 lane=%0d uop=%h",
                                i, out_valid, out_lane, out_uop, exp_lane, exp_uop);
            end
        end
        total++; if (credits !== 4'd4) begin bad++; $display("FAIL rr_credits: got %0d expected 4", credits); end
        lane_valid = '0;
        next_cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_drain_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_credit_return();
        do_reset();
        out_ready     = 1'b1;
        lane_valid    = 3'b001;
        set_uops(24'h0c0001, 24'h0c1111, 24'h0c2222);
        next_cycle();
        next_cycle();
        lane_valid    = '0;
        credit_return = 1'b1;
        next_cycle();
        total++; if (credits !== 4'd7) begin bad++; $display("FAIL cr_return_one: got %0d expected 7", credits); end
        next_cycle();
        next_cycle();
        total++; if (credits !== 4'd8) begin bad++; $display("FAIL cr_saturate: got %0d expected 8", credits); end
        lane_valid = 3'b001;
        #1;
        total++; if (lane_ready !== 3'b001) begin bad++; $display("FAIL cr_full_grant_ready: got %b expected 001", lane_ready); end
        next_cycle();
        total++; if (credits !== 4'd8) begin bad++; $display("FAIL cr_grant_and_return: got %0d expected 8", credits); end
        lane_valid    = '0;
        credit_return = 1'b0;
        next_cycle();
    endtask

    task automatic test_credit_stall();
        int grants;
        do_reset();
        set_uops(24'h0a0a0a, 24'h0b0b0b, 24'h0c0c0c);
        lane_valid    = 3'b001;
        out_ready     = 1'b1;
        credit_return = 1'b0;
        grants        = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (lane_valid[0] && lane_ready[0]) grants++;
            next_cycle();
        end
        total++; if (grants !== 8) begin bad++; $display("FAIL stall_grant_count: got %0d expected 8", grants); end
        total++; if (credits !== 4'd0) begin bad++; $display("FAIL stall_credits_zero: got %0d expected 0", credits); end
        credit_return = 1'b1;
        #1;
        total++; if (lane_ready !== 3'b000) begin bad++; $display("FAIL stall_same_cycle_ready: got %b expected 000", lane_ready); end
        next_cycle();
        credit_return = 1'b0;
        #1;
        total++; if ({credits, lane_ready} !== {4'd1, 3'b001}) begin
            bad++; $display("FAIL stall_return_grant: got credits=%0d ready=%b expected credits=1 ready=001", credits, lane_ready);
        end
        next_cycle();
        #1;
        total++; if ({credits, lane_ready, out_valid} !== {4'd0, 3'b000, 1'b1}) begin
            bad++; $display("FAIL stall_after_one: got credits=%0d ready=%b v=%b expected credits=0 ready=000 v=1",
                            credits, lane_ready, out_valid);
        end
        lane_valid = '0;
        next_cycle();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_uops(24'h0, 24'h5a5a01, 24'h0);
        lane_valid = 3'b010;
        out_ready  = 1'b0;
        #1;
        total++; if (lane_ready !== 3'b010) begin bad++; $display("FAIL bp_first_ready: got %b expected 010", lane_ready); end
        next_cycle();
        set_uops(24'h0, 24'h5a5a02, 24'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if ({lane_ready, out_valid, out_lane, out_uop} !== {3'b000, 1'b1, 2'd1, 24'h5a5a01}) begin
                bad++; $display("FAIL bp_hold[%0d]: got ready=%b v=%b lane=%0d uop=%h expected ready=000 v=1 lane=1 uop=5a5a01",
                                i, lane_ready, out_valid, out_lane, out_uop);
            end
            next_cycle();
        end
        out_ready = 1'b1;
        #1;
        total++; if (lane_ready !== 3'b010) begin bad++; $display("FAIL bp_release_ready: got %b expected 010", lane_ready); end
        next_cycle();
        total++; if ({out_uop, credits} !== {24'h5a5a02, 4'd6}) begin
            bad++; $display("FAIL bp_second_uop: got uop=%h credits=%0d expected uop=5a5a02 credits=6", out_uop, credits);
        end
        lane_valid = '0;
        next_cycle();
    endtask

    task automatic test_drain_barrier();
        do_reset();
        set_uops(24'hd00000, 24'hd11111, 24'hdeeeee);
        lane_valid = 3'b111;
        out_ready  = 1'b1;
        #1;
        total++; if (lane_ready !== 3'b001) begin bad++; $display("FAIL drain_ready0: got %b expected 001", lane_ready); end
        next_cycle();
        lane_valid = 3'b110;
        #1;
        total++; if ({out_lane, lane_ready} !== {2'd0, 3'b010}) begin
            bad++; $display("FAIL drain_step1: got lane=%0d ready=%b expected lane=0 ready=010", out_lane, lane_ready);
        end
        next_cycle();
        lane_valid = 3'b100;
        #1;
        total++; if ({out_lane, halted, lane_ready} !== {2'd1, 1'b0, 3'b100}) begin
            bad++; $display("FAIL drain_term_grant: got lane=%0d halted=%b ready=%b expected lane=1 halted=0 ready=100",
                            out_lane, halted, lane_ready);
        end
        next_cycle();
        lane_valid = 3'b001;
        set_uops(24'hd00001, 24'hd11111, 24'hdeeeee);
        #1;
        total++; if ({out_valid, out_lane, out_uop, halted, lane_ready} !== {1'b1, 2'd2, 24'hdeeeee, 1'b1, 3'b000}) begin
            bad++; $display("FAIL drain_term_out: got v=%b lane=%0d uop=%h halted=%b ready=%b expected v=1 lane=2 uop=deeeee halted=1 ready=000",
                            out_valid, out_lane, out_uop, halted, lane_ready);
        end
        next_cycle();
        #1;
        total++; if ({out_valid, halted, lane_ready} !== {1'b0, 1'b1, 3'b000}) begin
            bad++; $display("FAIL drain_halt_hold: got v=%b halted=%b ready=%b expected v=0 halted=1 ready=000",
                            out_valid, halted, lane_ready);
        end
        next_cycle();
        wakeup = 1'b1;
        #1;
        total++; if (lane_ready !== 3'b000) begin bad++; $display("FAIL drain_wakeup_cycle: got %b expected 000", lane_ready); end
        next_cycle();
        wakeup = 1'b0;
        #1;
        total++; if ({halted, lane_ready} !== {1'b0, 3'b001}) begin
            bad++; $display("FAIL drain_resume: got halted=%b ready=%b expected halted=0 ready=001", halted, lane_ready);
        end
        next_cycle();
        total++; if ({out_valid, out_lane, out_uop} !== {1'b1, 2'd0, 24'hd00001}) begin
            bad++; $display("FAIL drain_resume_out: got v=%b lane=%0d uop=%h expected v=1 lane=0 uop=d00001",
                            out_valid, out_lane, out_uop);
        end
        lane_valid = '0;
        next_cycle();
    endtask

    task automatic test_term_wakeup();
        do_reset();
        set_uops(24'hc00000, 24'h000000, 24'hcfffff);
        lane_valid = 3'b100;
        out_ready  = 1'b1;
        wakeup     = 1'b1;
        #1;
        total++; if (lane_ready !== 3'b000) begin bad++; $display("FAIL tw_run_no_term: got %b expected 000", lane_ready); end
        next_cycle();
        #1;
        total++; if ({halted, lane_ready} !== {1'b0, 3'b100}) begin
            bad++; $display("FAIL tw_term_grant: got halted=%b ready=%b expected halted=0 ready=100", halted, lane_ready);
        end
        next_cycle();
        lane_valid = 3'b001;
        wakeup     = 1'b0;
        #1;
        total++; if ({halted, out_valid, out_lane, lane_ready} !== {1'b0, 1'b1, 2'd2, 3'b001}) begin
            bad++; $display("FAIL tw_back_to_run: got halted=%b v=%b lane=%0d ready=%b expected halted=0 v=1 lane=2 ready=001",
                            halted, out_valid, out_lane, lane_ready);
        end
        next_cycle();
        total++; if ({halted, out_lane} !== {1'b0, 2'd0}) begin
            bad++; $display("FAIL tw_next_grant: got halted=%b lane=%0d expected halted=0 lane=0", halted, out_lane);
        end
        lane_valid = '0;
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_uops(24'hb00000, 24'hb11111, 24'h0);
        lane_valid = 3'b001;
        out_ready  = 1'b1;
        for (int i = 0; i < 5; i++) next_cycle();
        total++; if ({out_valid, credits} !== {1'b1, 4'd3}) begin
            bad++; $display("FAIL mid_precondition: got v=%b credits=%0d expected v=1 credits=3", out_valid, credits);
        end
        rst_n      = 1'b0;
        lane_valid = '0;
        next_cycle();
        rst_n = 1'b1;
        total++; if ({out_valid, credits, halted} !== {1'b0, 4'd8, 1'b0}) begin
            bad++; $display("FAIL mid_reset_state: got v=%b credits=%0d halted=%b expected v=0 credits=8 halted=0",
                            out_valid, credits, halted);
        end
        lane_valid = 3'b011;
        #1;
        total++; if (lane_ready !== 3'b001) begin bad++; $display("FAIL mid_first_grant: got %b expected 001", lane_ready); end
        next_cycle();
        total++; if ({out_lane, out_uop} !== {2'd0, 24'hb00000}) begin
            bad++; $display("FAIL mid_first_out: got lane=%0d uop=%h expected lane=0 uop=b00000", out_lane, out_uop);
        end
        lane_valid = '0;
        next_cycle();
    endtask

    initial begin
        rst_n         = 1'b0;
        lane_uop      = '0;
        lane_valid    = '0;
        wakeup        = 1'b0;
        out_ready     = 1'b0;
        credit_return = 1'b0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_credit_return();
        test_credit_stall();
        test_backpressure();
        test_drain_barrier();
        test_term_wakeup();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
